// File: rtl/ret_stack_check_if.sv
// Retired call/return event bus and check-result bundle
// for the committed return-stack checker.
interface ret_stack_check_if #(
    parameter int ADDR_WIDTH = 43,
    parameter int DEPTH_LOG  = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  except;
    logic                  except_thread;
    logic                  ret_en;
    logic                  ret_thread;
    logic                  ret_is_call;
    logic                  ret_is_ret;
    logic [ADDR_WIDTH-1:0] ret_lnk;
    logic [ADDR_WIDTH-1:0] ret_target;
    logic [ADDR_WIDTH-1:0] ret_pred;

    logic                  chk_valid;
    logic                  chk_thread;
    logic                  chk_miss;
    logic [ADDR_WIDTH-1:0] chk_target;
    logic [CNT_WIDTH-1:0]  miss_cnt;
    logic [DEPTH_LOG:0]    depth0;
    logic [DEPTH_LOG:0]    depth1;

    modport master (
        output except,
        output except_thread,
        output ret_en,
        output ret_thread,
        output ret_is_call,
        output ret_is_ret,
        output ret_lnk,
        output ret_target,
        output ret_pred,
        input  chk_valid,
        input  chk_thread,
        input  chk_miss,
        input  chk_target,
        input  miss_cnt,
        input  depth0,
        input  depth1
    );

    modport slave (
        input  except,
        input  except_thread,
        input  ret_en,
        input  ret_thread,
        input  ret_is_call,
        input  ret_is_ret,
        input  ret_lnk,
        input  ret_target,
        input  ret_pred,
        output chk_valid,
        output chk_thread,
        output chk_miss,
        output chk_target,
        output miss_cnt,
        output depth0,
        output depth1
    );
endinterface

// File: rtl/ret_stack_check.sv
// Committed per-thread return stack; checks retired returns
// against frontend predictions and reports mispredicts.
module ret_stack_check #(
    parameter int ADDR_WIDTH = 43,
    parameter int DEPTH_LOG  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    ret_stack_check_if.slave io
);
    localparam int ENTRIES = 1 << DEPTH_LOG;

    typedef logic [DEPTH_LOG-1:0]  ptr_t;
    typedef logic [DEPTH_LOG:0]    dep_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam dep_t DEPTH_FULL = dep_t'(ENTRIES);
    localparam dep_t DEPTH_ONE  = dep_t'(1);

    addr_t stk     [2][ENTRIES];
    ptr_t  top_q   [2];
    dep_t  depth_q [2];

    ptr_t  top_nxt   [2];
    dep_t  depth_nxt [2];

    logic  th;
    logic  accept;
    logic  do_call;
    logic  do_ret;
    logic  do_both;
    logic  is_ret;
    logic  miss;
    logic  wr_en;
    ptr_t  wr_ptr;
    ptr_t  cur_top;
    dep_t  cur_depth;
    ptr_t  ev_top;
    dep_t  ev_depth;
    addr_t expected;

    always_comb begin
        th        = io.ret_thread;
        cur_top   = top_q[th];
        cur_depth = depth_q[th];
        expected  = stk[th][cur_top];

        // A flush of the event's own thread swallows the event.
        accept = io.ret_en
               && (io.ret_is_call || io.ret_is_ret)
               && !(io.except && (io.except_thread == th));

        do_both = accept && io.ret_is_call && io.ret_is_ret;
        do_call = accept && io.ret_is_call && !io.ret_is_ret;
        do_ret  = accept && io.ret_is_ret && !io.ret_is_call;
        is_ret  = do_both || do_ret;

        miss = (cur_depth == '0)
            || (io.ret_pred != expected)
            || (io.ret_target != expected);

        wr_en    = 1'b0;
        wr_ptr   = cur_top;
        ev_top   = cur_top;
        ev_depth = cur_depth;

        unique case (1'b1)
            do_both: begin
                wr_en = 1'b1;
                if (cur_depth == '0)
                    ev_depth = DEPTH_ONE;
            end
            do_call: begin
                ev_top = cur_top + 1'b1;
                wr_en  = 1'b1;
                wr_ptr = ev_top;
                if (cur_depth != DEPTH_FULL)
                    ev_depth = cur_depth + 1'b1;
            end
            do_ret: begin
                ev_top = cur_top - 1'b1;
                if (cur_depth != '0)
                    ev_depth = cur_depth - 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            top_nxt[i]   = top_q[i];
            depth_nxt[i] = depth_q[i];
            if (io.except && (io.except_thread == 1'(i))) begin
                top_nxt[i]   = '1;
                depth_nxt[i] = '0;
            end else if (accept && (th == 1'(i))) begin
                top_nxt[i]   = ev_top;
                depth_nxt[i] = ev_depth;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                top_q[i]   <= '1;
                depth_q[i] <= '0;
                for (int j = 0; j < ENTRIES; j++)
                    stk[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                top_q[i]   <= top_nxt[i];
                depth_q[i] <= depth_nxt[i];
            end
            if (wr_en)
                stk[th][wr_ptr] <= io.ret_lnk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io.chk_valid  <= 1'b0;
            io.chk_thread <= 1'b0;
            io.chk_miss   <= 1'b0;
            io.chk_target <= '0;
            io.miss_cnt   <= '0;
        end else begin
            io.chk_valid <= is_ret;
            io.chk_miss  <= is_ret && miss;
            if (is_ret) begin
                io.chk_thread <= th;
                io.chk_target <= io.ret_target;
            end
            if (is_ret && miss && (io.miss_cnt != '1))
                io.miss_cnt <= io.miss_cnt + 1'b1;
        end
    end

    assign io.depth0 = depth_q[0];
    assign io.depth1 = depth_q[1];
endmodule

// File: tb/tb_ret_stack_check.sv
// Directed bench for the committed return-stack checker.
// Expected values are hand-computed per vector.
module tb_ret_stack_check;
    localparam int AW = 43;
    localparam int DL = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ret_stack_check_if #(
        .ADDR_WIDTH(AW),
        .DEPTH_LOG (DL),
        .CNT_WIDTH (CW)
    ) bus ();

    ret_stack_check #(
        .ADDR_WIDTH(AW),
        .DEPTH_LOG (DL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(
        input logic          t,
        input logic          c,
        input logic          r,
        input logic [AW-1:0] lnk,
        input logic [AW-1:0] tgt,
        input logic [AW-1:0] pred
    );
        bus.ret_en      = 1'b1;
        bus.ret_thread  = t;
        bus.ret_is_call = c;
        bus.ret_is_ret  = r;
        bus.ret_lnk     = lnk;
        bus.ret_target  = tgt;
        bus.ret_pred    = pred;
        step();
        bus.ret_en      = 1'b0;
        bus.ret_is_call = 1'b0;
        bus.ret_is_ret  = 1'b0;
    endtask

    task automatic call(input logic t, input logic [AW-1:0] lnk);
        ev(t, 1'b1, 1'b0, lnk, '0, '0);
    endtask

    task automatic ret(
        input logic          t,
        input logic [AW-1:0] tgt,
        input logic [AW-1:0] pred
    );
        ev(t, 1'b0, 1'b1, '0, tgt, pred);
    endtask

    initial begin
        bus.except        = 1'b0;
        bus.except_thread = 1'b0;
        bus.ret_en        = 1'b0;
        bus.ret_thread    = 1'b0;
        bus.ret_is_call   = 1'b0;
        bus.ret_is_ret    = 1'b0;
        bus.ret_lnk       = '0;
        bus.ret_target    = '0;
        bus.ret_pred      = '0;

        repeat (2) step();
        check("rst_valid", 64'(bus.chk_valid), 64'd0);
        check("rst_miss", 64'(bus.chk_miss), 64'd0);
        check("rst_tgt", 64'(bus.chk_target), 64'd0);
        check("rst_cnt", 64'(bus.miss_cnt), 64'd0);
        check("rst_d0", 64'(bus.depth0), 64'd0);
        check("rst_d1", 64'(bus.depth1), 64'd0);
        rst = 1'b1;
        step();

        // basic hit on thread 0
        call(1'b0, 43'h100);
        check("c1_d0", 64'(bus.depth0), 64'd1);
        check("c1_valid", 64'(bus.chk_valid), 64'd0);
        ret(1'b0, 43'h100, 43'h100);
        check("r1_valid", 64'(bus.chk_valid), 64'd1);
        check("r1_miss", 64'(bus.chk_miss), 64'd0);
        check("r1_tgt", 64'(bus.chk_target), 64'h100);
        check("r1_thr", 64'(bus.chk_thread), 64'd0);
        check("r1_d0", 64'(bus.depth0), 64'd0);
        step();
        check("idle_valid", 64'(bus.chk_valid), 64'd0);

        // empty pop on thread 1
        ret(1'b1, 43'h55, 43'h55);
        check("e_valid", 64'(bus.chk_valid), 64'd1);
        check("e_miss", 64'(bus.chk_miss), 64'd1);
        check("e_tgt", 64'(bus.chk_target), 64'h55);
        check("e_thr", 64'(bus.chk_thread), 64'd1);
        check("e_d1", 64'(bus.depth1), 64'd0);
        check("e_cnt", 64'(bus.miss_cnt), 64'd1);

        // wrong prediction
        call(1'b0, 43'h200);
        ret(1'b0, 43'h200, 43'h300);
        check("p_miss", 64'(bus.chk_miss), 64'd1);
        check("p_tgt", 64'(bus.chk_target), 64'h200);
        check("p_cnt", 64'(bus.miss_cnt), 64'd2);
        check("p_d0", 64'(bus.depth0), 64'd0);

        // overflow: 17 pushes, oldest lost
        for (int i = 1; i <= 17; i++)
            call(1'b0, AW'(i));
        check("ov_d0", 64'(bus.depth0), 64'd16);
        for (int i = 17; i >= 2; i--) begin
            ret(1'b0, AW'(i), AW'(i));
            check($sformatf("ov_miss%0d", i), 64'(bus.chk_miss), 64'd0);
        end
        check("ov_d0_end", 64'(bus.depth0), 64'd0);
        ret(1'b0, 43'h1, 43'h1);
        check("ov_last_v", 64'(bus.chk_valid), 64'd1);
        check("ov_last_m", 64'(bus.chk_miss), 64'd1);
        check("ov_cnt", 64'(bus.miss_cnt), 64'd3);

        // flush thread 1 drops its own event
        call(1'b0, 43'hA);
        call(1'b1, 43'hA);
        check("x_d1_pre", 64'(bus.depth1), 64'd1);
        bus.except        = 1'b1;
        bus.except_thread = 1'b1;
        ret(1'b1, 43'hA, 43'hA);
        bus.except = 1'b0;
        check("x_valid", 64'(bus.chk_valid), 64'd0);
        check("x_d1", 64'(bus.depth1), 64'd0);
        check("x_d0", 64'(bus.depth0), 64'd1);
        ret(1'b0, 43'hA, 43'hA);
        check("x_r0_v", 64'(bus.chk_valid), 64'd1);
        check("x_r0_m", 64'(bus.chk_miss), 64'd0);
        check("x_cnt", 64'(bus.miss_cnt), 64'd3);

        // flush thread 0 leaves thread-1 event alone
        call(1'b0, 43'h44);
        call(1'b1, 43'h33);
        bus.except        = 1'b1;
        bus.except_thread = 1'b0;
        ret(1'b1, 43'h33, 43'h33);
        bus.except = 1'b0;
        check("y_valid", 64'(bus.chk_valid), 64'd1);
        check("y_miss", 64'(bus.chk_miss), 64'd0);
        check("y_thr", 64'(bus.chk_thread), 64'd1);
        check("y_d0", 64'(bus.depth0), 64'd0);
        check("y_d1", 64'(bus.depth1), 64'd0);

        // co-routine return-and-call
        call(1'b0, 43'h10);
        ev(1'b0, 1'b1, 1'b1, 43'h20, 43'h10, 43'h10);
        check("b_valid", 64'(bus.chk_valid), 64'd1);
        check("b_miss", 64'(bus.chk_miss), 64'd0);
        check("b_d0", 64'(bus.depth0), 64'd1);
        ret(1'b0, 43'h20, 43'h20);
        check("b2_miss", 64'(bus.chk_miss), 64'd0);
        check("b2_tgt", 64'(bus.chk_target), 64'h20);
        check("b2_d0", 64'(bus.depth0), 64'd0);
        check("b_cnt", 64'(bus.miss_cnt), 64'd3);

        // co-routine on empty stack: miss, depth becomes 1
        ev(1'b1, 1'b1, 1'b1, 43'h77, 43'h5, 43'h5);
        check("be_miss", 64'(bus.chk_miss), 64'd1);
        check("be_d1", 64'(bus.depth1), 64'd1);
        check("be_cnt", 64'(bus.miss_cnt), 64'd4);
        ret(1'b1, 43'h77, 43'h77);
        check("be2_miss", 64'(bus.chk_miss), 64'd0);
        check("be2_d1", 64'(bus.depth1), 64'd0);

        step();
        check("end_valid", 64'(bus.chk_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ret_stack_check.md
Name: ret_stack_check

Overview:
- Retirement-side counterpart of the frontend return-address stack. The frontend pushes on predicted calls and pops on predicted returns. This block consumes retired call/return events and keeps a committed (architectural) return stack per thread.
- For each retired return, it checks the frontend's predicted target against the actual target. On a miss it raises a registered mispredict indication, carrying the correct target, to the redirect logic.
- Two hardware threads. No backpressure: one event per cycle.

Parameters:
ADDR_WIDTH, 43, width of return address (bits [46:4] of fetch address)
DEPTH_LOG, 4, log2 of committed stack entries per thread (16)
CNT_WIDTH, 16, width of saturating miss counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
except  input  1  pipeline flush; clears committed stack of except_thread
except_thread  input  1  thread being flushed
ret_en  input  1  retired control-transfer event valid
ret_thread  input  1  thread of event
ret_is_call  input  1  event pushes link address
ret_is_ret  input  1  event pops and checks
ret_lnk  input  ADDR_WIDTH  return address pushed by call
ret_target  input  ADDR_WIDTH  actual target of return
ret_pred  input  ADDR_WIDTH  target predicted by frontend for this return
chk_valid  output  1  check result valid (one cycle)
chk_thread  output  1  thread of result
chk_miss  output  1  prediction wrong or stack empty
chk_target  output  ADDR_WIDTH  correct target (= ret_target of checked return)
miss_cnt  output  CNT_WIDTH  saturating total miss count
depth0  output  DEPTH_LOG+1  committed depth, thread 0
depth1  output  DEPTH_LOG+1  committed depth, thread 1

Behaviour:
- Reset (rst low, async), for both threads:
  - top pointer = all-ones, depth = 0, all entries = 0.
  - chk_valid = 0, chk_miss = 0, chk_thread = 0, chk_target = 0, miss_cnt = 0.
- Storage:
  - 2 x 2^DEPTH_LOG register array, indexed {thread, ptr}.
  - Pointer arithmetic is modulo 2^DEPTH_LOG (wraps).
- Per accepted event (ret_en=1, no overriding except):
  - Return only (ret_is_ret=1, ret_is_call=0):
    - Compare ret_target against entry[top] if depth>0.
    - top = top-1; depth = depth-1 (not below 0).
  - Call only (ret_is_call=1, ret_is_ret=0):
    - top = top+1; entry[top+1] = ret_lnk.
    - depth = min(depth+1, 2^DEPTH_LOG). Push at full overwrites the oldest entry via the wrap.
  - Both set (co-routine return-and-call):
    - Check as a return against the old top.
    - Then overwrite entry[top] with ret_lnk. top and depth unchanged. If depth was 0, depth becomes 1.
  - Neither set: no state change, no result.
- Check rule (return events):
  - The expected target is entry[top] if depth>0.
  - chk_miss = (depth==0) OR (ret_pred != expected) OR (ret_target != expected).
  - Empty pop is always a miss; the pop leaves depth at 0.
- Latency:
  - A return accepted in cycle N produces chk_valid=1 in cycle N+1, with chk_thread, chk_miss and chk_target=ret_target registered.
  - chk_valid is low in every cycle with no return event in the previous cycle.
- miss_cnt increments in the same cycle chk_miss is registered high, and saturates at all-ones.
- Stack reads use pre-update state. An event in cycle N+1 sees the pushes/pops of cycle N. There are no read-during-write hazards across cycles.
- except:
  - Sets top of except_thread to all-ones and depth to 0. Other thread unaffected.
  - If ret_en is also set with ret_thread==except_thread, the event is dropped: no state change, chk_valid=0 next cycle.
  - An event on the other thread proceeds normally.
- depth0/depth1 are registered, post-update values.

Test Plan:
- Reset then call(lnk=0x100), return(target=0x100, pred=0x100) on thread 0:
  - chk_valid=1, chk_miss=0, chk_target=0x100 one cycle after the return.
  - depth0 = 1 then 0.
- Return on empty thread 1 (target=0x55, pred=0x55) -> chk_miss=1, chk_target=0x55, depth1 stays 0, miss_cnt=1.
- Call 0x200 then return with pred=0x300, target=0x200 -> chk_miss=1, chk_target=0x200, miss_cnt increments.
- 17 calls (lnk=1..17) on thread 0, then 16 returns with matching targets 17..2 -> all chk_miss=0, depth0 peaks at 16. A 17th return is a miss (depth 0).
- Call 0xA on both threads; except with except_thread=1 together with a return on thread 1 -> no chk_valid, depth1=0. A thread-0 return to 0xA still hits.
- Call 0x10 then event with ret_is_call=ret_is_ret=1 (lnk=0x20, target=0x10, pred=0x10) -> hit, depth stays 1. Next return with target 0x20 hits.
